// File: rtl/bomb_sequencer.sv
// Bomb game controller driving an external NONE/LOAD/INCR/DECR timer register; commands are combinational, flags registered.
// Optional BOMB_STRIKE_SPEEDUP_EN: each non-fatal wrong code halves the tick period (minimum 2 cycles).
module bomb_sequencer #(
  parameter int                 WIDTH       = 4,
  parameter int                 MAX_TIME    = 15,
  parameter int                 TICK_DIV    = 50000000,
  parameter int                 CODE_W      = 8,
  parameter logic [CODE_W-1:0]  DEFUSE_CODE = 8'hA5,
  parameter int                 MAX_STRIKES = 3
) (
  input  logic              clk,
  input  logic              async_nreset,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              btn_arm,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_in,
  input  logic [WIDTH-1:0]  timer_val,
  output logic [1:0]        timer_ctrl,
  output logic [WIDTH-1:0]  timer_load,
  output logic              armed,
  output logic              defused,
  output logic              exploded,
  output logic [1:0]        strikes
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0]       CTRL_NONE = 2'd0;
  localparam logic [1:0]       CTRL_LOAD = 2'd1;
  localparam logic [1:0]       CTRL_INCR = 2'd2;
  localparam logic [1:0]       CTRL_DECR = 2'd3;
  localparam logic [WIDTH-1:0] MAX_T     = WIDTH'(MAX_TIME);
  localparam logic [1:0]       MAX_S     = 2'(MAX_STRIKES);

  typedef enum logic [1:0] {
    ST_SETUP    = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DEFUSED  = 2'd2,
    ST_EXPLODED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      strikes_q, strikes_d;
  logic            armed_q, defused_q, exploded_q;
  logic [1:0]      ctrl_cmd;
  logic [1:0]      strike_inc;
  logic [PW-1:0]   last_cnt;
  logic            tick;
  logic            speedup;

`ifdef BOMB_STRIKE_SPEEDUP_EN
  logic [31:0] period_w;
  always_comb begin
    period_w = 32'(TICK_DIV) >> strikes_q;
    if (period_w < 32'd2) period_w = 32'd2;
  end
  assign last_cnt = PW'(period_w - 32'd1);
  assign speedup  = 1'b1;
`else
  assign last_cnt = PW'(TICK_DIV - 1);
  assign speedup  = 1'b0;
`endif

  assign tick       = (presc_q == last_cnt);
  assign strike_inc = (strikes_q == MAX_S) ? strikes_q : strikes_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    strikes_d = strikes_q;
    ctrl_cmd  = CTRL_NONE;
    case (state_q)
      ST_SETUP: begin
        presc_d = '0;
        // Arm owns the cycle even when it is refused at zero.
        if (btn_arm) begin
          if (timer_val != '0) begin
            state_d   = ST_ARMED;
            strikes_d = 2'd0;
          end
        end else if (btn_inc && !btn_dec) begin
          if (timer_val < MAX_T) ctrl_cmd = CTRL_INCR;
        end else if (btn_dec && !btn_inc) begin
          if (timer_val != '0) ctrl_cmd = CTRL_DECR;
        end
      end
      ST_ARMED: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (code_valid && code_in == DEFUSE_CODE) begin
          state_d = ST_DEFUSED;
        end else if (code_valid && strike_inc == MAX_S) begin
          state_d   = ST_EXPLODED;
          strikes_d = strike_inc;
        end else begin
          if (code_valid) begin
            strikes_d = strike_inc;
            if (speedup) presc_d = '0;
          end
          if (tick) begin
            // Never step below zero; an empty timer on a tick just explodes.
            if (timer_val != '0) ctrl_cmd = CTRL_DECR;
            if (timer_val <= WIDTH'(1)) state_d = ST_EXPLODED;
          end
        end
      end
      ST_DEFUSED, ST_EXPLODED: begin
        if (btn_arm) begin
          ctrl_cmd  = CTRL_LOAD;
          state_d   = ST_SETUP;
          strikes_d = 2'd0;
          presc_d   = '0;
        end
      end
      default: state_d = ST_SETUP;
    endcase
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q    <= ST_SETUP;
      presc_q    <= '0;
      strikes_q  <= 2'd0;
      armed_q    <= 1'b0;
      defused_q  <= 1'b0;
      exploded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      strikes_q  <= strikes_d;
      armed_q    <= (state_d == ST_ARMED);
      defused_q  <= (state_d == ST_DEFUSED);
      exploded_q <= (state_d == ST_EXPLODED);
    end
  end

  // Reset gates the command path so nothing reaches the timer while held.
  assign timer_ctrl = async_nreset ? ctrl_cmd : CTRL_NONE;
  assign timer_load = '0;
  assign armed      = armed_q;
  assign defused    = defused_q;
  assign exploded   = exploded_q;
  assign strikes    = strikes_q;

  a_no_decr_at_zero: assert property (@(posedge clk) disable iff (!async_nreset)
    !(state_q == ST_ARMED && timer_val == '0 && timer_ctrl == CTRL_DECR));
  a_flags_exclusive: assert property (@(posedge clk) disable iff (!async_nreset)
    $onehot0({armed_q, defused_q, exploded_q}));

endmodule
